// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the tiny-riscv core.
// Strobes are combinational from the state register; state and counters are registered.
module core_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  output logic             ir_load,
  input  logic             is_load_op,
  input  logic             is_store_op,
  input  logic             is_br_type,
  input  logic             is_jump_op,
  input  logic             is_writeback,
  input  logic             br_taken,
  output logic             dmem_req_valid,
  output logic             dmem_req_we,
  input  logic             dmem_req_ready,
  input  logic             dmem_rsp_valid,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             retire,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    FETCH_WAIT = 3'd2,
    DECODE     = 3'd3,
    EXECUTE    = 3'd4,
    MEM_REQ    = 3'd5,
    MEM_WAIT   = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic   is_mem;

  assign is_mem  = is_load_op | is_store_op;
  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    ir_load        = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_req_we    = 1'b0;
    rf_we          = 1'b0;
    pc_we          = 1'b0;
    pc_sel         = 1'b0;
    retire         = 1'b0;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: if (imem_rsp_valid) begin
        ir_load = 1'b1;
        state_d = DECODE;
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        if (is_mem) begin
          state_d = MEM_REQ;
        end else begin
          rf_we   = is_writeback;
          pc_we   = 1'b1;
          pc_sel  = is_jump_op | (is_br_type & br_taken);
          retire  = 1'b1;
          state_d = run ? FETCH : IDLE;
        end
      end
      MEM_REQ: begin
        dmem_req_valid = 1'b1;
        // A load+store decode collision resolves to a load.
        dmem_req_we    = is_store_op & ~is_load_op;
        if (dmem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: if (dmem_rsp_valid) begin
        rf_we   = is_load_op & is_writeback;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != IDLE) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (retire)          instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule
